// File: rtl/fifo_drain_pkg.sv
// ============================================================================
// fifo_drain_pkg: shared types, constants and helpers for the fifo_drain block.
// Rev 1.0
// ============================================================================
`default_nettype none

package fifo_drain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } drain_state_t;

    localparam int SKID_DEPTH = 2;
    localparam int STAT_WIDTH = 32;

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] value);
        return (&value) ? value : value + STAT_WIDTH'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_drain_skid.sv
// ============================================================================
// fifo_drain_skid: two-entry in-order buffer; the head entry is always presented.
// Rev 1.0
// ============================================================================
`default_nettype none

module fifo_drain_skid
    import fifo_drain_pkg::*;
#(
    parameter int DW = 33
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          valid,
    output logic [DW-1:0] head_data,
    output logic [1:0]    cnt
);

    logic [DW-1:0] mem [SKID_DEPTH];
    logic          head;
    logic          tail;

    // Storage is cleared on reset so the stream outputs read zero while idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
            head <= 1'b0;
            tail <= 1'b0;
            cnt  <= 2'd0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign valid     = (cnt != 2'd0);
    assign head_data = mem[head];

endmodule

`default_nettype wire

// File: rtl/fifo_drain.sv
// ============================================================================
// fifo_drain: absorbs FIFO read latency and re-presents words on a valid/ready
// stream with burst framing; FIFO_DRAIN_STATS_EN adds word/stall counters. Rev 1.0
// ============================================================================
`default_nettype none

module fifo_drain
    import fifo_drain_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic             fifo_write,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_read,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             busy
`ifdef FIFO_DRAIN_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] word_count,
    output logic [STAT_WIDTH-1:0] stall_count
`endif
);

    localparam int                BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    drain_state_t      state;
    drain_state_t      state_next;
    logic              inflight;
    logic [BEAT_W-1:0] beat;
    logic [BEAT_W-1:0] beat_next;
    logic [1:0]        cnt;
    logic [2:0]        credit;
    logic              read_ok;
    logic              pop;
    logic              cap_last;
    logic [WIDTH:0]    head_word;

    assign pop    = m_valid && m_ready;
    assign credit = {1'b0, cnt} + {2'b00, inflight};

    // Occupancy after this cycle's pop must stay below the buffer depth.
    assign read_ok   = (credit < 3'd2) || ((credit == 3'd2) && pop);
    assign fifo_read = (state == RUN) && !fifo_empty && !fifo_write && read_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_read;
        end
    end

    assign beat_next = (beat == LAST_BEAT) ? '0 : beat + BEAT_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat <= '0;
        end else if (pop) begin
            beat <= beat_next;
        end
    end

    // The captured word sits behind cnt buffered words, so its burst position is beat+cnt.
    assign cap_last = (cnt != 2'd0) ? (beat_next == LAST_BEAT) : (beat == LAST_BEAT);

    fifo_drain_skid #(
        .DW (WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (inflight),
        .push_data ({cap_last, fifo_data}),
        .pop       (pop),
        .valid     (m_valid),
        .head_data (head_word),
        .cnt       (cnt)
    );

    assign m_data = head_word[WIDTH-1:0];
    assign m_last = head_word[WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (en) state_next = RUN;
            end
            RUN: begin
                if (!en) state_next = DRAIN;
            end
            DRAIN: begin
                if (en) begin
                    state_next = RUN;
                end else if ((cnt == 2'd0) && !inflight) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

`ifdef FIFO_DRAIN_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_count  <= '0;
            stall_count <= '0;
        end else begin
            if (pop) begin
                word_count <= sat_inc(word_count);
            end
            if (m_valid && !m_ready) begin
                stall_count <= sat_inc(stall_count);
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_drain.sv
// Self-checking bench for fifo_drain: FIFO model with one-cycle read latency,
// scoreboard of expected {last, data} words, and per-scenario tasks.
`default_nettype none

module tb_fifo_drain;

    localparam int WIDTH     = 32;
    localparam int BURST_LEN = 4;

    logic             clk        = 1'b0;
    logic             reset_n    = 1'b0;
    logic             en         = 1'b0;
    logic             fifo_empty;
    logic             fifo_write = 1'b0;
    logic [WIDTH-1:0] fifo_data  = 'z;
    logic [WIDTH-1:0] wdata      = '0;
    logic             fifo_read;
    logic             m_valid;
    logic             m_ready    = 1'b0;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             busy;
    logic             flush      = 1'b0;
`ifdef FIFO_DRAIN_STATS_EN
    logic [31:0]      word_count;
    logic [31:0]      stall_count;
`endif

    int checks   = 0;
    int errors   = 0;
    int idx      = 0;
    int fifo_cnt = 0;

    logic [WIDTH-1:0] fq[$];
    logic [WIDTH:0]   sb[$];
    logic [WIDTH:0]   exp_w;

    always #5 clk = ~clk;

    fifo_drain #(
        .WIDTH     (WIDTH),
        .BURST_LEN (BURST_LEN)
    ) dut (
`ifdef FIFO_DRAIN_STATS_EN
        .word_count  (word_count),
        .stall_count (stall_count),
`endif
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_write (fifo_write),
        .fifo_data  (fifo_data),
        .fifo_read  (fifo_read),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy)
    );

    // FIFO model: read accepted only without a coincident write; data one cycle later, Z otherwise.
    assign fifo_empty = (fifo_cnt == 0);

    always @(posedge clk) begin
        if (flush) begin
            fq.delete();
            fifo_data <= 'z;
        end else begin
            if (fifo_read && !fifo_write && fq.size() > 0) fifo_data <= fq.pop_front();
            else                                           fifo_data <= 'z;
            if (fifo_write) fq.push_back(wdata);
        end
        fifo_cnt <= fq.size();
    end

    // Scoreboard: every accepted stream word is compared against the next expected word.
    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            if ($isunknown(fifo_read)) begin
                errors++;
                $display("FAIL fifo_read_known: got %b want 0 or 1", fifo_read);
            end
            if (m_valid && m_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got last=%b data=%h want no word", m_last, m_data);
                end else begin
                    exp_w = sb.pop_front();
                    if ({m_last, m_data} !== exp_w) begin
                        errors++;
                        $display("FAIL sb_word: got last=%b data=%h want last=%b data=%h",
                                 m_last, m_data, exp_w[WIDTH], exp_w[WIDTH-1:0]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int n, input logic [WIDTH-1:0] base);
        for (int i = 0; i < n; i++) begin
            wdata      = base + WIDTH'(i);
            fifo_write = 1'b1;
            sb.push_back({((idx % BURST_LEN) == BURST_LEN - 1), wdata});
            idx++;
            tick();
        end
        fifo_write = 1'b0;
    endtask

    task automatic do_reset();
        en         = 1'b0;
        m_ready    = 1'b0;
        fifo_write = 1'b0;
        reset_n    = 1'b0;
        flush      = 1'b1;
        tick();
        flush = 1'b0;
        sb.delete();
        idx = 0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic drain_words(input int n, input string name);
        int pops = 0;
        for (int i = 0; i < 100 && pops < n; i++) begin
            #1;
            if (m_valid && m_ready) pops++;
            tick();
        end
        checks++;
        if (pops != n || sb.size() != 0) begin
            errors++;
            $display("FAIL %s_pops: got %0d pops, %0d left want %0d pops, 0 left", name, pops, sb.size(), n);
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 50; i++) begin
            if (!busy) break;
            tick();
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_timeout: got busy=%b want 0", name, busy);
        end
    endtask

    task automatic test_reset();
        #2;
        checks += 5;
        if (fifo_read !== 1'b0) begin errors++; $display("FAIL rst_fifo_read: got %b want 0", fifo_read); end
        if (m_valid !== 1'b0)   begin errors++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        if (m_data !== '0)      begin errors++; $display("FAIL rst_m_data: got %h want 0", m_data); end
        if (m_last !== 1'b0)    begin errors++; $display("FAIL rst_m_last: got %b want 0", m_last); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        logic             rd  [10];
        logic             vld [10];
        logic [WIDTH-1:0] dat [10];
        logic             lst [10];
        logic [WIDTH-1:0] words [3];
        words[0] = 32'hA000_0001;
        words[1] = 32'hB000_0002;
        words[2] = 32'hC000_0003;
        do_reset();
        load(3, 32'h0);
        sb.delete();
        idx = 0;
        for (int i = 0; i < 3; i++) begin
            sb.push_back({1'b0, words[i]});
            idx++;
        end
        // Replace the preloaded FIFO contents with A, B, C directly through writes.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wdata      = words[i];
            fifo_write = 1'b1;
            tick();
        end
        fifo_write = 1'b0;
        m_ready    = 1'b1;
        en         = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            #1;
            rd[c]  = fifo_read;
            vld[c] = m_valid;
            dat[c] = m_data;
            lst[c] = m_last;
        end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (rd[c] !== (c <= 2)) begin
                errors++;
                $display("FAIL stream_read_c%0d: got %b want %b", c, rd[c], (c <= 2));
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (vld[k+2] !== 1'b1 || dat[k+2] !== words[k] || lst[k+2] !== 1'b0) begin
                errors++;
                $display("FAIL stream_word%0d: got v=%b d=%h l=%b want v=1 d=%h l=0",
                         k, vld[k+2], dat[k+2], lst[k+2], words[k]);
            end
        end
        checks++;
        if (vld[1] !== 1'b0 || vld[5] !== 1'b0) begin
            errors++;
            $display("FAIL stream_valid_window: got v1=%b v5=%b want 0 0", vld[1], vld[5]);
        end
        en = 1'b0;
        wait_idle("stream");
    endtask

    task automatic test_burst();
        logic [7:0] lastmask = '0;
        int         n = 0;
        do_reset();
        load(8, 32'h1000_0000);
        m_ready = 1'b1;
        en      = 1'b1;
        for (int i = 0; i < 40 && n < 8; i++) begin
            #1;
            if (m_valid && m_ready) begin
                lastmask[n] = m_last;
                n++;
            end
            tick();
        end
        checks++;
        if (n != 8 || lastmask !== 8'b1000_1000) begin
            errors++;
            $display("FAIL burst_last: got n=%0d mask=%b want n=8 mask=10001000", n, lastmask);
        end
        en = 1'b0;
        wait_idle("burst");
    endtask

    task automatic test_backpressure();
        int reads = 0;
        do_reset();
        load(5, 32'h2000_0000);
        m_ready = 1'b0;
        en      = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            #1;
            if (fifo_read) reads++;
        end
        checks += 3;
        if (reads != 2) begin errors++; $display("FAIL bp_reads: got %0d want 2", reads); end
        if (fifo_read !== 1'b0) begin errors++; $display("FAIL bp_read_stop: got %b want 0", fifo_read); end
        if (m_valid !== 1'b1 || m_data !== 32'h2000_0000) begin
            errors++;
            $display("FAIL bp_hold: got v=%b d=%h want v=1 d=20000000", m_valid, m_data);
        end
        tick();
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'h2000_0000) begin
            errors++;
            $display("FAIL bp_hold2: got v=%b d=%h want v=1 d=20000000", m_valid, m_data);
        end
        m_ready = 1'b1;
        drain_words(5, "bp");
        en = 1'b0;
        wait_idle("bp");
    endtask

    task automatic test_write_suppress();
        do_reset();
        load(2, 32'h3000_0000);
        m_ready = 1'b1;
        en      = 1'b1;
        tick();
        wdata      = 32'h3000_0002;
        fifo_write = 1'b1;
        sb.push_back({((idx % BURST_LEN) == BURST_LEN - 1), wdata});
        idx++;
        #1;
        checks++;
        if (fifo_read !== 1'b0) begin errors++; $display("FAIL ws_suppress: got %b want 0", fifo_read); end
        tick();
        fifo_write = 1'b0;
        #1;
        checks++;
        if (fifo_read !== 1'b1) begin errors++; $display("FAIL ws_resume: got %b want 1", fifo_read); end
        drain_words(3, "ws");
        en = 1'b0;
        wait_idle("ws");
    endtask

    task automatic test_drain();
        int   pops    = 0;
        logic rd_seen = 1'b0;
        do_reset();
        load(4, 32'h4000_0000);
        m_ready = 1'b1;
        en      = 1'b1;
        tick();
        tick();
        en = 1'b0;
        #1;
        checks++;
        if (fifo_read !== 1'b1) begin errors++; $display("FAIL drain_last_read: got %b want 1", fifo_read); end
        tick();
        #1;
        checks++;
        if (busy !== 1'b1 || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL drain_enter: got busy=%b v=%b want 1 1", busy, m_valid);
        end
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            if (fifo_read) rd_seen = 1'b1;
            if (m_valid && m_ready) pops++;
            tick();
            #1;
        end
        checks += 3;
        if (rd_seen !== 1'b0) begin errors++; $display("FAIL drain_no_read: got %b want 0", rd_seen); end
        if (pops != 2)        begin errors++; $display("FAIL drain_pops: got %0d want 2", pops); end
        if (busy !== 1'b0)    begin errors++; $display("FAIL drain_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        load(6, 32'h5000_0000);
        m_ready = 1'b1;
        en      = 1'b1;
        repeat (4) tick();
        checks++;
        if (m_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b want 1", m_valid); end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({fifo_read, m_valid, m_last, busy} !== 4'b0 || m_data !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got rd=%b v=%b l=%b busy=%b d=%h want all 0",
                     fifo_read, m_valid, m_last, busy, m_data);
        end
        do_reset();
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_after: got busy=%b v=%b want 0 0", busy, m_valid);
        end
    endtask

`ifdef FIFO_DRAIN_STATS_EN
    task automatic test_stats();
        int seen = 0;
        do_reset();
        load(10, 32'h6000_0000);
        m_ready = 1'b0;
        en      = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            #1;
            if (m_valid) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (seen != 1) begin errors++; $display("FAIL stats_valid_timeout: got v=%b want 1", m_valid); end
        repeat (3) tick();
        m_ready = 1'b1;
        drain_words(10, "stats");
        en = 1'b0;
        wait_idle("stats");
        checks += 2;
        if (word_count !== 32'd10) begin errors++; $display("FAIL stats_words: got %0d want 10", word_count); end
        if (stall_count !== 32'd3) begin errors++; $display("FAIL stats_stalls: got %0d want 3", stall_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_burst();
        test_backpressure();
        test_write_suppress();
        test_drain();
        test_reset_mid();
`ifdef FIFO_DRAIN_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
